// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - alu_16 control encodings and muldiv_seq state type.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'b1001;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_IDLE = 4'b0000;

  localparam logic ALU_MODE_ARITH = 1'b0;
  localparam logic ALU_MODE_LOGIC = 1'b1;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/alu_16.sv
// rtl/alu_16.sv - 16-bit 74181/74182-style ALU (active-high data, active-low carry), arithmetic subset.
module alu_16
  import alu_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic        mode,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c_in,
  output logic [15:0] z,
  output logic        c_out
);

  logic [16:0] sum;

  // Carries are active-low on both sides, so c_in=1 means no carry in.
  always_comb begin
    sum   = 17'd0;
    z     = ~x;
    c_out = 1'b1;
    if (mode == ALU_MODE_ARITH) begin
      case (alu_op)
        ALU_OP_ADD: sum = {1'b0, x} + {1'b0, y} + {16'd0, ~c_in};
        ALU_OP_SUB: sum = {1'b0, x} + {1'b0, ~y} + {16'd0, ~c_in};
        default:    sum = {1'b0, x} + {16'd0, ~c_in};
      endcase
      z     = sum[15:0];
      c_out = ~sum[16];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - Multi-cycle unsigned multiply/divide sequencer driving an external alu_16.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero,
  output logic [3:0]       alu_op,
  output logic             alu_mode,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_c_out
);

  localparam int ITERS = WIDTH;
  localparam int CW    = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  muldiv_state_t    state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] r_sh;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign r_sh = {hi[WIDTH-2:0], lo[WIDTH-1]};

  // hi/lo hold the product halves for multiply and remainder/quotient for divide.
  always_comb begin
    alu_op   = ALU_OP_IDLE;
    alu_mode = ALU_MODE_LOGIC;
    alu_x    = '0;
    alu_y    = '0;
    alu_c_in = 1'b1;
    hi_nxt   = hi;
    lo_nxt   = lo;
    if (state == RUN) begin
      alu_mode = ALU_MODE_ARITH;
      if (op_q == MD_OP_MUL) begin
        alu_op   = ALU_OP_ADD;
        alu_x    = hi;
        alu_y    = a_q;
        alu_c_in = 1'b1;
        if (lo[0]) begin
          hi_nxt = {~alu_c_out, alu_z[WIDTH-1:1]};
          lo_nxt = {alu_z[0], lo[WIDTH-1:1]};
        end else begin
          hi_nxt = {1'b0, hi[WIDTH-1:1]};
          lo_nxt = {hi[0], lo[WIDTH-1:1]};
        end
      end else begin
        alu_op   = ALU_OP_SUB;
        alu_x    = r_sh;
        alu_y    = b_q;
        alu_c_in = 1'b0;
        // The bit shifted out of R means the partial remainder already exceeds b.
        if (hi[WIDTH-1] || !alu_c_out) begin
          hi_nxt = alu_z;
          lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_nxt = r_sh;
          lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= MD_OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      result_hi <= '0;
      result_lo <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (op == MD_OP_DIV && b == '0) begin
              state     <= DONE;
              result_lo <= '1;
              result_hi <= a;
              div_zero  <= 1'b1;
            end else begin
              state    <= RUN;
              hi       <= '0;
              lo       <= (op == MD_OP_MUL) ? b : a;
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            result_hi <= hi_nxt;
            result_lo <= lo_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - Directed-vector bench for muldiv_seq wired to alu_16.
module tb_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, div_zero;
  logic [15:0] result_hi, result_lo;
  logic [3:0]  alu_op;
  logic        alu_mode, alu_c_in, alu_c_out;
  logic [15:0] alu_x, alu_y, alu_z;

  int checks = 0;
  int failures = 0;
  int lat;
  int seen_done;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_zero(div_zero), .alu_op(alu_op), .alu_mode(alu_mode), .alu_x(alu_x),
    .alu_y(alu_y), .alu_c_in(alu_c_in), .alu_z(alu_z), .alu_c_out(alu_c_out)
  );

  alu_16 u_alu (
    .alu_op(alu_op), .mode(alu_mode), .x(alu_x), .y(alu_y), .c_in(alu_c_in),
    .z(alu_z), .c_out(alu_c_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic o, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a = 16'hdead; b = 16'hbeef;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [15:0] av,
                        input logic [15:0] bv, input int exp_lat, input logic [15:0] exp_hi,
                        input logic [15:0] exp_lo, input logic exp_dz);
    issue(o, av, bv);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_hi"}, result_hi, exp_hi);
    check({tag, "_lo"}, result_lo, exp_lo);
    check({tag, "_dz"}, div_zero, exp_dz);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_res", {result_hi, result_lo}, 32'h0);
    check("rst_alu", {alu_op, alu_mode, alu_c_in}, {ALU_OP_IDLE, 1'b1, 1'b1});
    check("rst_alu_xy", {alu_x, alu_y}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul3x5", MD_OP_MUL, 16'h0003, 16'h0005, 17, 16'h0000, 16'h000F, 1'b0);
    run_op("mulmax", MD_OP_MUL, 16'hFFFF, 16'hFFFF, 17, 16'hFFFE, 16'h0001, 1'b0);
    run_op("mul_ab", MD_OP_MUL, 16'h1234, 16'h5678, 17, 16'h0626, 16'h0060, 1'b0);
    run_op("div100_7", MD_OP_DIV, 16'd100, 16'd7, 17, 16'd2, 16'd14, 1'b0);
    run_op("div_t1", MD_OP_DIV, 16'hFFFF, 16'h8001, 17, 16'h7FFE, 16'h0001, 1'b0);
    run_op("div_small", MD_OP_DIV, 16'd5, 16'd9, 17, 16'd5, 16'd0, 1'b0);
    run_op("div0", MD_OP_DIV, 16'h1234, 16'h0000, 1, 16'h1234, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("div0_hold_dz", div_zero, 1);
    check("idle_alu", {alu_op, alu_mode, alu_c_in}, {ALU_OP_IDLE, 1'b1, 1'b1});
    run_op("mul_clr_dz", MD_OP_MUL, 16'h0002, 16'h0007, 17, 16'h0000, 16'h000E, 1'b0);

    // Starts at cycle 5 and at the DONE cycle of a running multiply must be ignored.
    issue(MD_OP_MUL, 16'h00FF, 16'h0101);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5 || k == 17) begin
        op = MD_OP_DIV; a = 16'h4444; b = 16'h0000; start = 1'b1;
      end
      if (k == 1) check("busy_c1", busy, 1);
      if (done && lat < 0) begin
        lat = k;
        check("busy_in_done", busy, 1);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (lat > 0) break;
    end
    check("ign_lat", lat, 17);
    check("ign_res", {result_hi, result_lo}, 32'h0000FFFF);
    check("ign_dz", div_zero, 0);
    @(negedge clk);
    check("ign_idle_busy", busy, 0);
    check("ign_idle_done", done, 0);

    // Reset in the middle of a divide.
    issue(MD_OP_DIV, 16'd1000, 16'd3);
    for (int k = 1; k < 8; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", {result_hi, result_lo}, 32'h0);
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (k == 3) reset_n = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_op("after_abort", MD_OP_DIV, 16'd1000, 16'd3, 17, 16'd1, 16'd333, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
